// File: rtl/id_ex_pkg.sv
// Shared widths and ALU opcode constants for the ID/EX stage.
// Memory ops reuse the add-immediate encoding because the ALU only forms rs1+imm for them.
package id_ex_pkg;
    localparam int DSIZE = 16;
    localparam int AW    = 4;
    localparam int OPW   = 3;

    localparam logic [OPW-1:0] NOP_OP  = 3'd0;
    localparam logic [OPW-1:0] OP_ADD  = 3'd1;
    localparam logic [OPW-1:0] OP_SUB  = 3'd2;
    localparam logic [OPW-1:0] OP_AND  = 3'd3;
    localparam logic [OPW-1:0] OP_XOR  = 3'd4;
    localparam logic [OPW-1:0] OP_COM  = 3'd5;
    localparam logic [OPW-1:0] OP_MUL  = 3'd6;
    localparam logic [OPW-1:0] OP_ADDI = 3'd7;
    localparam logic [OPW-1:0] OP_LW   = 3'd7;
    localparam logic [OPW-1:0] OP_SW   = 3'd7;
endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: r0 -> 0, then EX/MEM, then MEM/WB, then register-file data.
module fwd_mux
    import id_ex_pkg::*;
#(
    parameter int DW = DSIZE
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] rdata,
    input  logic          exmem_wr_en,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_wr_en,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_wdata,
    output logic [DW-1:0] fwd
);
    always_comb begin
        fwd = rdata;
        if (rs == '0) begin
            fwd = '0;
        end else if (exmem_wr_en && (exmem_rd == rs)) begin
            fwd = exmem_result;
        end else if (memwb_wr_en && (memwb_rd == rs)) begin
            fwd = memwb_wdata;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and ALU operand forwarding.
// Optional hazard counters (stall_cnt/flush_cnt) are built when ID_EX_HAZARD_CNT_EN is defined.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW = DSIZE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_op,
    input  logic [AW-1:0]  id_rs1,
    input  logic [AW-1:0]  id_rs2,
    input  logic [DW-1:0]  id_rdata1,
    input  logic [DW-1:0]  id_rdata2,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_use_imm,
    input  logic           id_wr_en,
    input  logic [AW-1:0]  id_rd,
    input  logic           id_mem_rd,
    input  logic           id_mem_wr,
    input  logic           exmem_wr_en,
    input  logic [AW-1:0]  exmem_rd,
    input  logic [DW-1:0]  exmem_result,
    input  logic           memwb_wr_en,
    input  logic [AW-1:0]  memwb_rd,
    input  logic [DW-1:0]  memwb_wdata,
    input  logic           flush,
    input  logic           hold,
    output logic           stall_out,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    output logic           ex_valid,
    output logic [AW-1:0]  ex_rd,
    output logic           ex_wr_en,
    output logic           ex_mem_rd,
    output logic           ex_mem_wr,
    output logic [DW-1:0]  ex_store_data
`ifdef ID_EX_HAZARD_CNT_EN
    ,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    flush_cnt
`endif
);
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [AW-1:0]  rs1;
        logic [AW-1:0]  rs2;
        logic [DW-1:0]  rdata1;
        logic [DW-1:0]  rdata2;
        logic [DW-1:0]  imm;
        logic           use_imm;
        logic [AW-1:0]  rd;
        logic           wr_en;
        logic           mem_rd;
        logic           mem_wr;
        logic           valid;
    } ex_slot_t;

    ex_slot_t      ex;
    logic          load_use;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;

    // rs2 only matters when it is a real B operand or the store data of SW.
    always_comb begin
        load_use = id_valid && ex.valid && ex.mem_rd && (ex.rd != '0) &&
                   ((ex.rd == id_rs1) ||
                    ((ex.rd == id_rs2) && (!id_use_imm || id_mem_wr)));
    end

    assign stall_out = load_use && !flush && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex <= '0;
        end else if (!hold) begin
            if (flush || load_use) begin
                ex.valid  <= 1'b0;
                ex.wr_en  <= 1'b0;
                ex.mem_rd <= 1'b0;
                ex.mem_wr <= 1'b0;
            end else begin
                ex.op      <= id_op;
                ex.rs1     <= id_rs1;
                ex.rs2     <= id_rs2;
                ex.rdata1  <= id_rdata1;
                ex.rdata2  <= id_rdata2;
                ex.imm     <= id_imm;
                ex.use_imm <= id_use_imm;
                ex.rd      <= id_rd;
                ex.wr_en   <= id_wr_en && id_valid;
                ex.mem_rd  <= id_mem_rd && id_valid;
                ex.mem_wr  <= id_mem_wr && id_valid;
                ex.valid   <= id_valid;
            end
        end
    end

    fwd_mux #(.DW(DW)) u_fwd1 (
        .rs(ex.rs1), .rdata(ex.rdata1),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .fwd(fwd1)
    );

    fwd_mux #(.DW(DW)) u_fwd2 (
        .rs(ex.rs2), .rdata(ex.rdata2),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .fwd(fwd2)
    );

    assign alu_a         = fwd1;
    assign alu_b         = ex.use_imm ? ex.imm : fwd2;
    assign ex_store_data = fwd2;
    assign alu_op        = ex.valid ? ex.op : NOP_OP;
    assign ex_valid      = ex.valid;
    assign ex_rd         = ex.rd;
    assign ex_wr_en      = ex.wr_en && ex.valid;
    assign ex_mem_rd     = ex.mem_rd && ex.valid;
    assign ex_mem_wr     = ex.mem_wr && ex.valid;

`ifdef ID_EX_HAZARD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_out && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && !hold && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
// Counter checks are compiled in when ID_EX_HAZARD_CNT_EN is defined.
module tb_id_ex_stage;
    import id_ex_pkg::*;
    localparam int DW = DSIZE;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid;
    logic [OPW-1:0] id_op;
    logic [AW-1:0]  id_rs1, id_rs2, id_rd;
    logic [DW-1:0]  id_rdata1, id_rdata2, id_imm;
    logic           id_use_imm, id_wr_en, id_mem_rd, id_mem_wr;
    logic           exmem_wr_en;
    logic [AW-1:0]  exmem_rd;
    logic [DW-1:0]  exmem_result;
    logic           memwb_wr_en;
    logic [AW-1:0]  memwb_rd;
    logic [DW-1:0]  memwb_wdata;
    logic           flush, hold;
    logic           stall_out;
    logic [DW-1:0]  alu_a, alu_b, ex_store_data;
    logic [OPW-1:0] alu_op;
    logic           ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr;
    logic [AW-1:0]  ex_rd;
`ifdef ID_EX_HAZARD_CNT_EN
    logic [15:0]    stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .flush(flush), .hold(hold), .stall_out(stall_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data)
`ifdef ID_EX_HAZARD_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
        id_use_imm = 0; id_wr_en = 0; id_mem_rd = 0; id_mem_wr = 0;
        exmem_wr_en = 0; exmem_rd = '0; exmem_result = '0;
        memwb_wr_en = 0; memwb_rd = '0; memwb_wdata = '0;
        flush = 0; hold = 0;
    endtask

    task automatic drive_id(input logic [OPW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                            input logic use_imm, input logic wr, input logic [AW-1:0] rd,
                            input logic mrd, input logic mwr);
        id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rdata1 = d1; id_rdata2 = d2;
        id_imm = imm; id_use_imm = use_imm; id_wr_en = wr; id_rd = rd; id_mem_rd = mrd; id_mem_wr = mwr;
    endtask

    // Reference forwarding value for a source register, from the current bypass inputs.
    function automatic logic [DW-1:0] fwd_ref(input logic [AW-1:0] rs, input logic [DW-1:0] d);
        if (rs == 0) return '0;
        if (exmem_wr_en && exmem_rd == rs) return exmem_result;
        if (memwb_wr_en && memwb_rd == rs) return memwb_wdata;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1; clear_inputs();
        #12;
        n_cmp++;
        if ({ex_valid, alu_op, alu_a, alu_b, stall_out, ex_wr_en, ex_mem_rd, ex_mem_wr} !== '0) begin
            n_err++; $display("FAIL reset_power_on got valid=%b op=%h a=%h b=%h stall=%b exp all 0",
                              ex_valid, alu_op, alu_a, alu_b, stall_out);
        end
        @(posedge clk); #1; rst = 0;
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0010, 16'h0, 16'h0004, 1, 1, 4'd5, 1, 0);
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_mem_rd !== 1'b1 || alu_op !== OP_LW || alu_a !== 16'h0010 || alu_b !== 16'h0004) begin
            n_err++; $display("FAIL reset_lw_loaded got valid=%b mrd=%b op=%h a=%h b=%h exp 1 1 %h 0010 0004",
                              ex_valid, ex_mem_rd, alu_op, alu_a, alu_b, OP_LW);
        end
        drive_id(OP_ADD, 4'd5, 4'd2, 16'h0, 16'h0, 16'h0, 0, 1, 4'd6, 0, 0);
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL reset_prestall got stall=%b exp 1", stall_out);
        end
        rst = 1;
        #1;
        n_cmp++;
        if ({ex_valid, alu_op, alu_a, alu_b, stall_out, ex_mem_rd} !== '0) begin
            n_err++; $display("FAIL reset_async got valid=%b op=%h a=%h b=%h stall=%b exp all 0",
                              ex_valid, alu_op, alu_a, alu_b, stall_out);
        end
        step();
        rst = 0; clear_inputs();
    endtask

    task automatic test_exmem_fwd();
        clear_inputs();
        drive_id(OP_ADD, 4'd3, 4'd1, 16'h0005, 16'h0002, 16'h0, 0, 1, 4'd3, 0, 0);
        step();
        clear_inputs();
        exmem_wr_en = 1; exmem_rd = 4'd3; exmem_result = 16'h0042;
        memwb_wr_en = 1; memwb_rd = 4'd3; memwb_wdata = 16'h0099;
        #1;
        n_cmp++;
        if (alu_a !== 16'h0042 || alu_op !== OP_ADD || alu_b !== 16'h0002) begin
            n_err++; $display("FAIL exmem_priority got a=%h op=%h b=%h exp 0042 %h 0002", alu_a, alu_op, alu_b, OP_ADD);
        end
        exmem_wr_en = 0; #1;
        n_cmp++;
        if (alu_a !== 16'h0099) begin
            n_err++; $display("FAIL memwb_fwd got a=%h exp 0099", alu_a);
        end
        memwb_wr_en = 0; #1;
        n_cmp++;
        if (alu_a !== 16'h0005) begin
            n_err++; $display("FAIL no_fwd got a=%h exp 0005", alu_a);
        end
        exmem_wr_en = 1; exmem_rd = 4'd1; exmem_result = 16'h0ABC; #1;
        n_cmp++;
        if (alu_b !== 16'h0ABC || ex_store_data !== 16'h0ABC) begin
            n_err++; $display("FAIL exmem_rs2 got b=%h sd=%h exp 0abc", alu_b, ex_store_data);
        end
    endtask

    task automatic test_r0_guard();
        clear_inputs();
        drive_id(OP_ADD, 4'd0, 4'd0, 16'h7777, 16'h5555, 16'h0, 0, 1, 4'd2, 0, 0);
        step();
        clear_inputs();
        exmem_wr_en = 1; exmem_rd = 4'd0; exmem_result = 16'h1234;
        memwb_wr_en = 1; memwb_rd = 4'd0; memwb_wdata = 16'h4321;
        #1;
        n_cmp++;
        if (alu_b !== 16'h0 || alu_a !== 16'h0 || ex_store_data !== 16'h0) begin
            n_err++; $display("FAIL r0_guard got a=%h b=%h sd=%h exp 0", alu_a, alu_b, ex_store_data);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0020, 16'h0, 16'h0008, 1, 1, 4'd4, 1, 0);
        step();
        drive_id(OP_ADD, 4'd4, 4'd2, 16'hDEAD, 16'h0003, 16'h0, 0, 1, 4'd6, 0, 0);
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall got %b exp 1", stall_out);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || alu_op !== NOP_OP || ex_wr_en !== 1'b0 || stall_out !== 1'b0) begin
            n_err++; $display("FAIL load_use_bubble got valid=%b op=%h wr=%b stall=%b exp 0 0 0 0",
                              ex_valid, alu_op, ex_wr_en, stall_out);
        end
        memwb_wr_en = 1; memwb_rd = 4'd4; memwb_wdata = 16'h0007;
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || alu_op !== OP_ADD || alu_a !== 16'h0007 || alu_b !== 16'h0003 ||
            ex_rd !== 4'd6 || ex_wr_en !== 1'b1) begin
            n_err++; $display("FAIL load_use_resume got valid=%b op=%h a=%h b=%h rd=%h wr=%b exp 1 %h 0007 0003 6 1",
                              ex_valid, alu_op, alu_a, alu_b, ex_rd, ex_wr_en, OP_ADD);
        end
        clear_inputs();
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0020, 16'h0, 16'h0008, 1, 1, 4'd4, 1, 0);
        step();
        drive_id(OP_ADDI, 4'd1, 4'd4, 16'h0, 16'h0, 16'h0001, 1, 1, 4'd7, 0, 0);
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL imm_rs2_no_stall got %b exp 0", stall_out);
        end
        drive_id(OP_SW, 4'd1, 4'd4, 16'h0, 16'h0, 16'h0001, 1, 0, 4'd0, 0, 1);
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL sw_rs2_stall got %b exp 1", stall_out);
        end
        clear_inputs();
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0, 16'h0, 16'h0, 1, 1, 4'd0, 1, 0);
        step();
        drive_id(OP_ADD, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 4'd3, 0, 0);
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL r0_load_no_stall got %b exp 0", stall_out);
        end
        clear_inputs();
    endtask

    task automatic test_flush_hold();
        clear_inputs();
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0030, 16'h0, 16'h0002, 1, 1, 4'd4, 1, 0);
        step();
        drive_id(OP_ADD, 4'd4, 4'd2, 16'h0, 16'h0, 16'h0, 0, 1, 4'd6, 0, 0);
        flush = 1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL flush_stall got %b exp 0", stall_out);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0 || ex_mem_rd !== 1'b0 || alu_op !== NOP_OP) begin
            n_err++; $display("FAIL flush_squash got valid=%b wr=%b mrd=%b op=%h exp 0 0 0 0",
                              ex_valid, ex_wr_en, ex_mem_rd, alu_op);
        end
        flush = 0;
        drive_id(OP_LW, 4'd1, 4'd0, 16'h0030, 16'h0, 16'h0002, 1, 1, 4'd4, 1, 0);
        step();
        drive_id(OP_ADD, 4'd4, 4'd2, 16'h0, 16'h0, 16'h0, 0, 1, 4'd6, 0, 0);
        hold = 1; flush = 1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL hold_stall got %b exp 0", stall_out);
        end
        step();
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_mem_rd !== 1'b1 || ex_wr_en !== 1'b1 || ex_rd !== 4'd4 ||
            alu_op !== OP_LW || alu_a !== 16'h0030 || alu_b !== 16'h0002) begin
            n_err++; $display("FAIL hold_freeze got valid=%b mrd=%b wr=%b rd=%h op=%h a=%h b=%h exp 1 1 1 4 %h 0030 0002",
                              ex_valid, ex_mem_rd, ex_wr_en, ex_rd, alu_op, alu_a, alu_b, OP_LW);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic           m_valid, m_use_imm, m_wr, m_mrd, m_mwr;
        logic [OPW-1:0] m_op;
        logic [AW-1:0]  m_rs1, m_rs2, m_rd;
        logic [DW-1:0]  m_d1, m_d2, m_imm;
        logic           exp_hz;
        logic [DW-1:0]  exp_b;
        clear_inputs();
        rst = 1; #1; rst = 0;
        m_valid = 0; m_use_imm = 0; m_wr = 0; m_mrd = 0; m_mwr = 0;
        m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_op      = OPW'($urandom_range(0, 7));
            id_rs1     = AW'($urandom_range(0, 4));
            id_rs2     = AW'($urandom_range(0, 4));
            id_rd      = AW'($urandom_range(0, 4));
            id_rdata1  = DW'($urandom);
            id_rdata2  = DW'($urandom);
            id_imm     = DW'($urandom);
            id_use_imm = 1'($urandom_range(0, 1));
            id_wr_en   = 1'($urandom_range(0, 1));
            id_mem_rd  = ($urandom_range(0, 2) == 0);
            id_mem_wr  = ($urandom_range(0, 3) == 0);
            exmem_wr_en  = 1'($urandom_range(0, 1));
            exmem_rd     = AW'($urandom_range(0, 4));
            exmem_result = DW'($urandom);
            memwb_wr_en  = 1'($urandom_range(0, 1));
            memwb_rd     = AW'($urandom_range(0, 4));
            memwb_wdata  = DW'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            #1;
            exp_hz = id_valid && m_valid && m_mrd && (m_rd != 0) &&
                     ((m_rd == id_rs1) || ((m_rd == id_rs2) && (!id_use_imm || id_mem_wr)));
            n_cmp++;
            if (stall_out !== (exp_hz && !flush && !hold)) begin
                n_err++; $display("FAIL rnd_stall it=%0d got %b exp %b", i, stall_out, exp_hz && !flush && !hold);
            end
            n_cmp++;
            if (ex_valid !== m_valid || alu_op !== (m_valid ? m_op : NOP_OP) || ex_wr_en !== (m_valid && m_wr) ||
                ex_mem_rd !== (m_valid && m_mrd) || ex_mem_wr !== (m_valid && m_mwr)) begin
                n_err++; $display("FAIL rnd_ctrl it=%0d got v=%b op=%h wr=%b mrd=%b mwr=%b exp v=%b op=%h wr=%b mrd=%b mwr=%b",
                                  i, ex_valid, alu_op, ex_wr_en, ex_mem_rd, ex_mem_wr,
                                  m_valid, m_valid ? m_op : NOP_OP, m_valid && m_wr, m_valid && m_mrd, m_valid && m_mwr);
            end
            if (m_valid) begin
                exp_b = m_use_imm ? m_imm : fwd_ref(m_rs2, m_d2);
                n_cmp++;
                if (alu_a !== fwd_ref(m_rs1, m_d1) || alu_b !== exp_b ||
                    ex_store_data !== fwd_ref(m_rs2, m_d2) || ex_rd !== m_rd) begin
                    n_err++; $display("FAIL rnd_data it=%0d got a=%h b=%h sd=%h rd=%h exp a=%h b=%h sd=%h rd=%h",
                                      i, alu_a, alu_b, ex_store_data, ex_rd,
                                      fwd_ref(m_rs1, m_d1), exp_b, fwd_ref(m_rs2, m_d2), m_rd);
                end
            end
            @(posedge clk);
            if (!hold) begin
                if (flush || exp_hz) begin
                    m_valid = 0; m_wr = 0; m_mrd = 0; m_mwr = 0;
                end else begin
                    m_valid = id_valid; m_op = id_op; m_rs1 = id_rs1; m_rs2 = id_rs2;
                    m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm; m_use_imm = id_use_imm;
                    m_rd = id_rd; m_wr = id_wr_en && id_valid; m_mrd = id_mem_rd && id_valid;
                    m_mwr = id_mem_wr && id_valid;
                end
            end
            #1;
        end
        clear_inputs();
    endtask

`ifdef ID_EX_HAZARD_CNT_EN
    task automatic test_counters();
        clear_inputs();
        rst = 1; #1; rst = 0;
        n_cmp++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_err++; $display("FAIL cnt_reset got s=%h f=%h exp 0 0", stall_cnt, flush_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            drive_id(OP_LW, 4'd1, 4'd0, 16'h0, 16'h0, 16'h0, 1, 1, 4'd4, 1, 0);
            step();
            drive_id(OP_ADD, 4'd4, 4'd2, 16'h0, 16'h0, 16'h0, 0, 1, 4'd6, 0, 0);
            step();
            clear_inputs();
            step();
        end
        flush = 1; step(); step();
        hold = 1; step();
        flush = 0; hold = 0;
        n_cmp++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd2) begin
            n_err++; $display("FAIL cnt_values got s=%0d f=%0d exp 3 2", stall_cnt, flush_cnt);
        end
        flush = 1;
        repeat (65540) @(posedge clk);
        #1; flush = 0;
        n_cmp++;
        if (flush_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL cnt_saturate got %h exp ffff", flush_cnt);
        end
        flush = 1; step(); flush = 0;
        n_cmp++;
        if (flush_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL cnt_hold_max got %h exp ffff", flush_cnt);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_exmem_fwd();
        test_r0_guard();
        test_load_use();
        test_flush_hold();
        test_random();
`ifdef ID_EX_HAZARD_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
